// File: rtl/segre_sb_drain_port.sv
// segre_sb_drain_port: memory-side receiver for store-buffer drain traffic.
// Drained (addr, data) words queue in a small in-order FIFO and retire one at a
// time as memory writes held until acknowledged. A load-hazard compare covers
// every queued entry. A watchdog turns an unacknowledged write into a sticky error.
//
// Handshake: an entry transfers on a rising clk_i edge where sb_valid_i and
// sb_ready_o are both 1. sb_ready_o depends only on registered state and rst_i,
// never on sb_valid_i. The store buffer must hold sb_addr_i/sb_data_i stable
// while sb_valid_i is 1 and the transfer has not yet happened.
module segre_sb_drain_port #(
  parameter int ADDR_SIZE   = 32,
  parameter int WORD_SIZE   = 32,
  parameter int FIFO_DEPTH  = 2,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sb_valid_i,
  input  logic [ADDR_SIZE-1:0] sb_addr_i,
  input  logic [WORD_SIZE-1:0] sb_data_i,
  output logic                 sb_ready_o,
  output logic                 mm_wr_o,
  output logic [ADDR_SIZE-1:0] mm_addr_o,
  output logic [WORD_SIZE-1:0] mm_data_o,
  input  logic                 mm_ack_i,
  input  logic [ADDR_SIZE-1:0] ld_addr_i,
  output logic                 ld_conflict_o,
  output logic                 drained_o,
  output logic                 err_o,
  output logic [1:0]           dbg_state_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [TMR_W-1:0] TMO_LAST_C = TMR_W'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [TMR_W-1:0]     r_timer;
  logic [TMR_W-1:0]     w_timer_next;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_count_next;
  logic [FIFO_DEPTH-1:0] r_valid;
  logic [ADDR_SIZE-1:0] r_addr_mem [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] r_data_mem [FIFO_DEPTH];
  logic                 w_push;
  logic                 w_pop;

  // Acceptance is gated by reset, a full FIFO and the error state; no full-bypass.
  assign sb_ready_o = !rst_i && (r_count < DEPTH_C) && (r_state != ST_ERROR);
  assign w_push     = sb_valid_i && sb_ready_o;
  assign w_pop      = (r_state == ST_ISSUE) && mm_ack_i;

  assign drained_o   = (r_count == '0) && (r_state == ST_IDLE);
  assign err_o       = (r_state == ST_ERROR);
  assign dbg_state_o = r_state;

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Next-state, watchdog and memory write outputs. IDLE looks at the post-edge
  // count so a push into an empty FIFO shows up on mm_wr_o one cycle later.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    mm_wr_o      = 1'b0;
    mm_addr_o    = '0;
    mm_data_o    = '0;
    case (r_state)
      ST_IDLE: begin
        w_timer_next = '0;
        if (w_count_next != '0) w_state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        mm_wr_o   = 1'b1;
        mm_addr_o = r_addr_mem[r_rd_ptr];
        mm_data_o = r_data_mem[r_rd_ptr];
        if (mm_ack_i) begin
          w_timer_next = '0;
          w_state_next = (w_count_next != '0) ? ST_ISSUE : ST_IDLE;
        end else if (r_timer == TMO_LAST_C) begin
          w_state_next = ST_ERROR;
        end else begin
          w_timer_next = r_timer + TMR_W'(1);
        end
      end
      ST_ERROR: begin
        w_state_next = ST_ERROR;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_timer_next = '0;
      end
    endcase
  end

  // FSM state and watchdog timer registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
    end
  end

  // FIFO bookkeeping: pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= w_count_next;
    end
  end

  // FIFO payload storage; entries are only meaningful while their valid bit is set.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr_mem[r_wr_ptr] <= sb_addr_i;
      r_data_mem[r_wr_ptr] <= sb_data_i;
    end
  end

  // Load hazard: full-width compare against every queued entry, head included.
  always_comb begin
    ld_conflict_o = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_valid[i] && (r_addr_mem[i] == ld_addr_i)) ld_conflict_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_segre_sb_drain_port.sv
// Bench for segre_sb_drain_port: directed scenarios followed by random traffic,
// all compared each cycle against a queue-based reference of the drain port.
module tb_segre_sb_drain_port;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int TMO   = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          sb_valid_i = 1'b0;
  logic [AW-1:0] sb_addr_i = '0;
  logic [DW-1:0] sb_data_i = '0;
  logic          sb_ready_o;
  logic          mm_wr_o;
  logic [AW-1:0] mm_addr_o;
  logic [DW-1:0] mm_data_o;
  logic          mm_ack_i = 1'b0;
  logic [AW-1:0] ld_addr_i = '0;
  logic          ld_conflict_o;
  logic          drained_o;
  logic          err_o;
  logic [1:0]    dbg_state_o;

  // clock / reset block
  always #5 clk_i = ~clk_i;

  segre_sb_drain_port #(
    .ADDR_SIZE(AW), .WORD_SIZE(DW), .FIFO_DEPTH(DEPTH), .ACK_TIMEOUT(TMO)
  ) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sb_valid_i(sb_valid_i), .sb_addr_i(sb_addr_i), .sb_data_i(sb_data_i),
    .sb_ready_o(sb_ready_o),
    .mm_wr_o(mm_wr_o), .mm_addr_o(mm_addr_o), .mm_data_o(mm_data_o),
    .mm_ack_i(mm_ack_i),
    .ld_addr_i(ld_addr_i), .ld_conflict_o(ld_conflict_o),
    .drained_o(drained_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // scoreboard / reference model: queue of pending {addr, data} entries
  logic [AW+DW-1:0] exp_q[$];
  bit               m_err   = 1'b0;
  bit               m_known = 1'b0;
  int               m_wait  = 0;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // driver: apply one cycle of inputs, check outputs at negedge, advance model at posedge
  task automatic cycle(input bit rst, input bit valid, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit ack, input logic [AW-1:0] ld);
    bit            e_ready, e_wr, e_conf, e_push, e_pop;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    rst_i      = rst;
    sb_valid_i = valid;
    sb_addr_i  = a;
    sb_data_i  = d;
    mm_ack_i   = ack;
    ld_addr_i  = ld;
    @(negedge clk_i);
    e_ready = !rst && (exp_q.size() < DEPTH) && !m_err;
    e_wr    = (exp_q.size() > 0) && !m_err;
    e_addr  = e_wr ? exp_q[0][AW+DW-1:DW] : '0;
    e_data  = e_wr ? exp_q[0][DW-1:0] : '0;
    e_conf  = 1'b0;
    foreach (exp_q[i]) if (exp_q[i][AW+DW-1:DW] == ld) e_conf = 1'b1;
    if (m_known || rst) check("sb_ready", sb_ready_o, e_ready);
    if (m_known) begin
      check("mm_wr", mm_wr_o, e_wr);
      check("mm_addr", mm_addr_o, e_addr);
      check("mm_data", mm_data_o, e_data);
      check("ld_conflict", ld_conflict_o, e_conf);
      check("drained", drained_o, exp_q.size() == 0);
      check("err", err_o, m_err);
    end
    @(posedge clk_i);
    if (rst) begin
      exp_q.delete();
      m_err   = 1'b0;
      m_wait  = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      e_push = valid && e_ready;
      e_pop  = e_wr && ack;
      if (e_pop) begin
        void'(exp_q.pop_front());
        m_wait = 0;
      end else if (e_wr) begin
        m_wait++;
        if (m_wait == TMO) m_err = 1'b1;
      end
      if (e_push) exp_q.push_back({a, d});
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, '0);
  endtask

  initial begin
    // reset held two cycles with a valid offer pending
    cycle(1, 1, 32'h55, 32'h66, 0, 32'h55);
    cycle(1, 1, 32'h55, 32'h66, 0, 32'h55);
    idle(2);

    // single store with immediate ack
    cycle(0, 1, 32'h100, 32'hCAFE, 1, 32'h100);
    cycle(0, 0, '0, '0, 1, 32'h100);
    idle(2);

    // fill to full, refused third offer, then drain in order
    cycle(0, 1, 32'h10, 32'h1010, 0, 32'h10);
    cycle(0, 1, 32'h20, 32'h2020, 0, 32'h20);
    cycle(0, 1, 32'h30, 32'h3030, 0, 32'h30);
    cycle(0, 0, '0, '0, 1, 32'h20);
    cycle(0, 0, '0, '0, 1, 32'h20);
    idle(2);

    // load hazard against head and tail entries
    cycle(0, 1, 32'h40, 32'h4040, 0, 32'h44);
    cycle(0, 1, 32'h44, 32'h4444, 0, 32'h44);
    cycle(0, 0, '0, '0, 0, 32'h44);
    cycle(0, 0, '0, '0, 0, 32'h48);
    cycle(0, 0, '0, '0, 1, 32'h44);
    cycle(0, 0, '0, '0, 1, 32'h44);
    cycle(0, 0, '0, '0, 0, 32'h44);
    idle(1);

    // ack timeout -> sticky error, frozen FIFO, exit only through reset
    cycle(0, 1, 32'hAA0, 32'hBEEF, 0, 32'hAA0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 32'hAA4, 32'h1, i == 6, 32'hAA0);
    cycle(1, 0, '0, '0, 0, 32'hAA0);
    idle(2);

    // pointer wrap with back-to-back writes
    for (int i = 0; i < 5; i++) cycle(0, 1, 32'h200 + 32'(4 * i), $urandom, 1, 32'h204);
    idle(2);

    // reset during an outstanding write, then a late ack
    cycle(0, 1, 32'h300, 32'h3333, 0, 32'h300);
    cycle(1, 0, '0, '0, 0, 32'h300);
    cycle(0, 0, '0, '0, 1, 32'h300);
    idle(2);

    // randomized traffic; ack is forced before the watchdog would fire
    for (int i = 0; i < 400; i++) begin
      bit            r_rst, r_val, r_ack;
      logic [AW-1:0] r_a, r_ld;
      r_rst = ($urandom_range(0, 63) == 0);
      r_val = ($urandom_range(0, 9) < 6);
      r_a   = 32'h40 + 32'(4 * $urandom_range(0, 3));
      r_ld  = 32'h40 + 32'(4 * $urandom_range(0, 3));
      r_ack = (m_wait == TMO - 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      cycle(r_rst, r_val, r_a, $urandom, r_ack, r_ld);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
